// File: rtl/conv_window_sequencer_if.sv
// Issue/result bus between the 3x3 convolution window sequencer and its MAC datapath.
// The master side is the sequencer; the slave side is the datapath (or a bench).
interface conv_window_sequencer_if;
  logic       start;
  logic       inHold;
  logic [9:0] rAddr;
  logic [1:0] weightCol;
  logic [3:0] index;
  logic       issueEn;
  logic       accClear;
  logic       outValid;
  logic [7:0] outAddr;
  logic       busy;
  logic       done;

  modport master (
    input  start, inHold,
    output rAddr, weightCol, index, issueEn, accClear,
    output outValid, outAddr, busy, done
  );

  modport slave (
    output start, inHold,
    input  rAddr, weightCol, index, issueEn, accClear,
    input  outValid, outAddr, busy, done
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// Walks every 3x3 window of a square feature map for each filter, issuing one
// pixel column per cycle and flagging each completed window sum.
module conv_window_sequencer #(
  parameter int IN_DIM      = 9,
  parameter int OUT_DIM     = 4,
  parameter int STRIDE      = 2,
  parameter int NUM_FILTERS = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  conv_window_sequencer_if.master bus
);

  localparam int XY_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  localparam logic [XY_W-1:0] XY_LAST    = XY_W'(OUT_DIM - 1);
  localparam logic [3:0]      INDEX_LAST = 4'(NUM_FILTERS - 1);
  localparam logic [9:0]      ROW_STEP   = 10'(STRIDE * IN_DIM);
  localparam logic [9:0]      COL_STEP   = 10'(STRIDE);
  localparam logic [7:0]      PLANE_SIZE = 8'(OUT_DIM * OUT_DIM);
  localparam logic [7:0]      ROW_SIZE   = 8'(OUT_DIM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;

  logic [1:0]      col_q;
  logic [XY_W-1:0] ox_q;
  logic [XY_W-1:0] oy_q;
  logic [3:0]      index_q;

  logic            out_valid_q;
  logic [7:0]      out_addr_q;

  logic            issue;
  logic            col_last;
  logic            ox_last;
  logic            oy_last;
  logic            index_last;
  logic            pass_last;
  logic [9:0]      pix_addr;
  logic [7:0]      win_addr;

  // A column is issued only while running and the input buffer is ready.
  assign issue      = (state_q == RUN) && !bus.inHold;
  assign col_last   = (col_q == 2'd2);
  assign ox_last    = (ox_q == XY_LAST);
  assign oy_last    = (oy_q == XY_LAST);
  assign index_last = (index_q == INDEX_LAST);
  assign pass_last  = col_last && ox_last && oy_last && index_last;

  assign pix_addr = 10'(oy_q) * ROW_STEP + 10'(ox_q) * COL_STEP + 10'(col_q);
  assign win_addr = 8'(index_q) * PLANE_SIZE + 8'(oy_q) * ROW_SIZE + 8'(ox_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output and next-state term gets a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_d       = state_q;
    bus.issueEn   = 1'b0;
    bus.accClear  = 1'b0;
    bus.weightCol = 2'd0;
    bus.rAddr     = 10'd0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        bus.weightCol = col_q;
        bus.rAddr     = pix_addr;
        bus.issueEn   = issue;
        bus.accClear  = issue && (col_q == 2'd0);
        if (issue && pass_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Loop nest, outer to inner: filter index, oy, ox, window column.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q   <= 2'd0;
      ox_q    <= '0;
      oy_q    <= '0;
      index_q <= 4'd0;
    end else if (issue) begin
      if (!col_last) begin
        col_q <= col_q + 2'd1;
      end else begin
        col_q <= 2'd0;
        if (!ox_last) begin
          ox_q <= ox_q + 1'b1;
        end else begin
          ox_q <= '0;
          if (!oy_last) begin
            oy_q <= oy_q + 1'b1;
          end else begin
            oy_q    <= '0;
            index_q <= index_last ? 4'd0 : index_q + 4'd1;
          end
        end
      end
    end
  end

  // The window sum is complete one cycle after its third column, even if the
  // buffer stalls in that cycle, so the flag is not gated by inHold.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= 8'd0;
    end else begin
      out_valid_q <= issue && col_last;
      if (issue && col_last) begin
        out_addr_q <= win_addr;
      end
    end
  end

  assign bus.index    = index_q;
  assign bus.outValid = out_valid_q;
  assign bus.outAddr  = out_addr_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Randomized self-checking bench: a loop-nest reference model predicts every
// issue, window result and handshake pulse of a pass.
module tb_conv_window_sequencer;

  localparam int IN_DIM      = 9;
  localparam int OUT_DIM     = 4;
  localparam int STRIDE      = 2;
  localparam int NUM_FILTERS = 8;
  localparam int WINDOWS     = NUM_FILTERS * OUT_DIM * OUT_DIM;
  localparam int TOTAL       = WINDOWS * 3;
  localparam int MAX_CYCLES  = 6000;

  typedef struct {
    int addr;
    int wc;
    int idx;
    bit clr;
  } issue_t;

  logic clock = 1'b0;
  logic reset;

  int checks   = 0;
  int failures = 0;
  int cap_addr [0:TOTAL-1];

  always #5 clock = ~clock;

  conv_window_sequencer_if bus ();

  conv_window_sequencer #(
    .IN_DIM      (IN_DIM),
    .OUT_DIM     (OUT_DIM),
    .STRIDE      (STRIDE),
    .NUM_FILTERS (NUM_FILTERS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".rAddr"},     32'(bus.rAddr),     32'd0);
    check({tag, ".weightCol"}, 32'(bus.weightCol), 32'd0);
    check({tag, ".index"},     32'(bus.index),     32'd0);
    check({tag, ".issueEn"},   32'(bus.issueEn),   32'd0);
    check({tag, ".accClear"},  32'(bus.accClear),  32'd0);
    check({tag, ".outValid"},  32'(bus.outValid),  32'd0);
    check({tag, ".outAddr"},   32'(bus.outAddr),   32'd0);
    check({tag, ".busy"},      32'(bus.busy),      32'd0);
    check({tag, ".done"},      32'(bus.done),      32'd0);
  endtask

  // Idle cycles with a wiggling inHold: nothing may move without a start.
  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bus.start  = 1'b0;
      bus.inHold = 1'($urandom_range(0, 1));
      #1;
      check("idle.busy",     32'(bus.busy),     32'd0);
      check("idle.issueEn",  32'(bus.issueEn),  32'd0);
      check("idle.outValid", 32'(bus.outValid), 32'd0);
      check("idle.done",     32'(bus.done),     32'd0);
    end
  endtask

  // One pass. Model phases: 0 RUN, 1 DRAIN, 2 DONE, 3 back in IDLE.
  task automatic run_pass(input int hold_pct, input bit directed_hold,
                          input bit stray_start, input int reset_at,
                          input bit capture);
    issue_t q[$];
    issue_t e;
    int  issued      = 0;
    int  windows     = 0;
    int  dut_valids  = 0;
    int  hold_cycles = 0;
    int  hold_left   = 0;
    int  done_at     = -1;
    int  phase       = 0;
    bit  prev_wc2    = 1'b0;
    bit  hold;
    bit  exp_issue;

    for (int f = 0; f < NUM_FILTERS; f++)
      for (int oy = 0; oy < OUT_DIM; oy++)
        for (int ox = 0; ox < OUT_DIM; ox++)
          for (int wc = 0; wc < 3; wc++) begin
            e.addr = (oy * STRIDE) * IN_DIM + ox * STRIDE + wc;
            e.wc   = wc;
            e.idx  = f;
            e.clr  = (wc == 0);
            q.push_back(e);
          end

    @(negedge clock);
    bus.start  = 1'b1;
    bus.inHold = 1'($urandom_range(0, 1));
    @(negedge clock);

    for (int cyc = 0; cyc < MAX_CYCLES && phase != 3; cyc++) begin
      hold = 1'b0;
      if (phase == 0) begin
        if (hold_left > 0) begin
          hold = 1'b1;
          hold_left--;
        end else if (!directed_hold || issued > 3) begin
          hold = ($urandom_range(0, 99) < hold_pct);
        end
      end else begin
        hold = 1'($urandom_range(0, 1));
      end
      bus.inHold = hold;
      bus.start  = stray_start && ((phase == 0 && issued == 100) || phase == 2);
      if (reset_at >= 0 && phase == 0 && issued == reset_at) reset = 1'b1;
      #1;

      check("busy",     32'(bus.busy),     32'd1);
      check("done",     32'(bus.done),     32'(phase == 2));
      check("outValid", 32'(bus.outValid), 32'(prev_wc2));
      if (bus.outValid) dut_valids++;
      if (bus.done && done_at < 0) done_at = cyc;
      if (prev_wc2) begin
        check("outAddr", 32'(bus.outAddr), 32'(windows));
        windows++;
      end

      exp_issue = (phase == 0) && !hold;
      check("issueEn", 32'(bus.issueEn), 32'(exp_issue));
      if (exp_issue) begin
        e = q.pop_front();
        check("rAddr",     32'(bus.rAddr),     32'(e.addr));
        check("weightCol", 32'(bus.weightCol), 32'(e.wc));
        check("index",     32'(bus.index),     32'(e.idx));
        check("accClear",  32'(bus.accClear),  32'(e.clr));
        if (capture) cap_addr[issued] = int'(bus.rAddr);
        prev_wc2 = (e.wc == 2);
        issued++;
        if (directed_hold && issued == 2) hold_left = 5;
        if (directed_hold && issued == 3) hold_left = 1;
      end else begin
        check("accClear.idle", 32'(bus.accClear), 32'd0);
        if (phase != 0) check("weightCol.idle", 32'(bus.weightCol), 32'd0);
        prev_wc2 = 1'b0;
        if (phase == 0) hold_cycles++;
      end

      if (reset) begin
        @(negedge clock);
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.inHold = 1'b0;
        #1;
        check_reset_values("midreset");
        return;
      end

      if (phase == 0 && issued == TOTAL) phase = 1;
      else if (phase == 1)               phase = 2;
      else if (phase == 2)               phase = 3;
      @(negedge clock);
    end

    check("pass.finished", 32'(phase), 32'd3);
    bus.start  = 1'b0;
    bus.inHold = 1'($urandom_range(0, 1));
    #1;
    check("after.busy",     32'(bus.busy),    32'd0);
    check("after.issueEn",  32'(bus.issueEn), 32'd0);
    check("pass.valids",    32'(dut_valids),  32'(WINDOWS));
    check("pass.length",    32'(done_at),     32'(TOTAL + hold_cycles + 1));
  endtask

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.inHold = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check_reset_values("reset");
    idle_check(4);

    // Plain pass with the documented address landmarks.
    run_pass(0, 1'b0, 1'b0, -1, 1'b1);
    check("addr.w0c0",   32'(cap_addr[0]),   32'd0);
    check("addr.w0c1",   32'(cap_addr[1]),   32'd1);
    check("addr.w0c2",   32'(cap_addr[2]),   32'd2);
    check("addr.w1c0",   32'(cap_addr[3]),   32'd2);
    check("addr.w1c1",   32'(cap_addr[4]),   32'd3);
    check("addr.w1c2",   32'(cap_addr[5]),   32'd4);
    check("addr.row1c0", 32'(cap_addr[12]),  32'd18);
    check("addr.row1c1", 32'(cap_addr[13]),  32'd19);
    check("addr.row1c2", 32'(cap_addr[14]),  32'd20);
    check("addr.lastc0", 32'(cap_addr[381]), 32'd60);
    check("addr.lastc1", 32'(cap_addr[382]), 32'd61);
    check("addr.lastc2", 32'(cap_addr[383]), 32'd62);

    // Directed 5-cycle stall after a middle column, stall after a last column, random stalls.
    run_pass(20, 1'b1, 1'b0, -1, 1'b0);

    // Stray starts mid-pass and in DONE must not launch a second pass.
    run_pass(10, 1'b0, 1'b1, -1, 1'b0);
    idle_check(3);

    // Reset mid-pass, then a fresh full pass from the beginning.
    run_pass(0, 1'b0, 1'b0, 200, 1'b0);
    idle_check(3);
    run_pass(15, 1'b0, 1'b0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
